// File: rtl/msx_slot_bridge.sv
// MSX cartridge-slot to internal-bus bridge: sync/filter strobes, one request pulse per Z80 cycle.
// Pulse 1 clk after detection; reads stall the Z80 via WAIT until ready or TIMEOUT expiry.
module msx_slot_bridge #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [15:0] slot_a,
  input  logic [7:0]  slot_d_in,
  output logic [7:0]  slot_d_out,
  output logic        slot_d_oe,
  input  logic        slot_n_rd,
  input  logic        slot_n_wr,
  input  logic        slot_n_iorq,
  input  logic        slot_n_merq,
  input  logic        slot_n_m1,
  input  logic        slot_n_sltsl,
  output logic        slot_n_wait,
  output logic [15:0] bus_address,
  output logic [7:0]  bus_write_data,
  output logic        bus_read,
  output logic        bus_write,
  output logic        bus_io,
  output logic        bus_memory,
  input  logic        bus_io_cs,
  input  logic        bus_memory_cs,
  input  logic        bus_read_ready,
  input  logic [7:0]  bus_read_data
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_WRITE, ST_READ_REQ, ST_READ_WAIT, ST_READ_DRIVE, ST_RELEASE
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t     state, nxt;
  logic [5:0] pins, s1, s2, s3, act;
  logic [7:0] cnt;
  logic       is_io;
  logic       act_rd, act_wr, act_iorq, act_merq, act_m1, act_sltsl;
  logic       detect, one_rw, io_cyc, mem_cyc, fwd_io, fwd_mem;

  // Bit order: {sltsl, m1, merq, iorq, wr, rd}; idle level is 1.
  assign pins = {slot_n_sltsl, slot_n_m1, slot_n_merq, slot_n_iorq, slot_n_wr, slot_n_rd};

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      s1 <= '1;
      s2 <= '1;
      s3 <= '1;
    end else begin
      s1 <= pins;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Active only after two consecutive synchronised low samples.
  assign act       = ~s2 & ~s3;
  assign act_rd    = act[0];
  assign act_wr    = act[1];
  assign act_iorq  = act[2];
  assign act_merq  = act[3];
  assign act_m1    = act[4];
  assign act_sltsl = act[5];

  always_comb begin
    one_rw  = act_rd ^ act_wr;
    detect  = (act_iorq & (act_rd | act_wr | act_m1)) | (act_merq & (act_rd | act_wr));
    io_cyc  = act_iorq & ~act_merq & ~act_m1 & one_rw;
    mem_cyc = act_merq & ~act_iorq & act_sltsl & one_rw;
    fwd_io  = io_cyc & bus_io_cs;
    fwd_mem = mem_cyc & bus_memory_cs;

    nxt = state;
    case (state)
      ST_IDLE: begin
        if (detect) begin
          if (!(fwd_io | fwd_mem)) nxt = ST_RELEASE;
          else if (act_wr)         nxt = ST_WRITE;
          else                     nxt = ST_READ_REQ;
        end
      end
      ST_WRITE:    nxt = ST_RELEASE;
      ST_READ_REQ: nxt = ST_READ_WAIT;
      ST_READ_WAIT: begin
        // A released strobe aborts the read before a late ready can drive the pins.
        if (s2[0])               nxt = ST_IDLE;
        else if (bus_read_ready) nxt = ST_READ_DRIVE;
        else if (cnt == TO_LAST) nxt = ST_RELEASE;
      end
      ST_READ_DRIVE: if (s2[0]) nxt = ST_IDLE;
      ST_RELEASE:    if (&s2[3:0]) nxt = ST_IDLE;
      default:       nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state          <= ST_IDLE;
      cnt            <= 8'd0;
      is_io          <= 1'b0;
      bus_address    <= 16'h0000;
      bus_write_data <= 8'h00;
      slot_d_out     <= 8'h00;
    end else begin
      state <= nxt;
      if (state == ST_IDLE && nxt != ST_RELEASE && nxt != ST_IDLE) begin
        bus_address <= slot_a;
        is_io       <= fwd_io;
        if (nxt == ST_WRITE) bus_write_data <= slot_d_in;
      end
      if (state == ST_READ_REQ)       cnt <= 8'd0;
      else if (state == ST_READ_WAIT) cnt <= cnt + 8'd1;
      if (state == ST_READ_WAIT && nxt == ST_READ_DRIVE) slot_d_out <= bus_read_data;
    end
  end

  assign bus_write   = (state == ST_WRITE);
  assign bus_read    = (state == ST_READ_REQ);
  assign bus_io      = (bus_write | bus_read) & is_io;
  assign bus_memory  = (bus_write | bus_read) & ~is_io;
  assign slot_n_wait = ~((state == ST_READ_REQ) | (state == ST_READ_WAIT));
  assign slot_d_oe   = (state == ST_READ_DRIVE);

endmodule

// File: tb/tb_msx_slot_bridge.sv
// Directed bench for msx_slot_bridge: scoreboard of expected bus requests and read data,
// checked by a per-cycle monitor running inside the stimulus sequence.
module tb_msx_slot_bridge;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic [15:0] slot_a = 16'h0000;
  logic [7:0]  slot_d_in = 8'h00;
  logic        slot_n_rd = 1'b1, slot_n_wr = 1'b1, slot_n_iorq = 1'b1;
  logic        slot_n_merq = 1'b1, slot_n_m1 = 1'b1, slot_n_sltsl = 1'b1;
  logic        bus_io_cs = 1'b0, bus_memory_cs = 1'b0;
  logic        bus_read_ready = 1'b0;
  logic [7:0]  bus_read_data = 8'h00;
  logic [7:0]  slot_d_out;
  logic        slot_d_oe, slot_n_wait;
  logic [15:0] bus_address;
  logic [7:0]  bus_write_data;
  logic        bus_read, bus_write, bus_io, bus_memory;

  logic        resp_en = 1'b0;
  int          resp_delay = 2;
  logic [7:0]  resp_data = 8'hA5;
  int          resp_cnt = 0;

  int total = 0, bad = 0;
  int pulses = 0, wait_low = 0, oe_hi = 0;
  logic oe_prev = 1'b0;
  logic [31:0] exp_q[$];
  logic [7:0]  rd_q[$];
  int p0, w0, o0, n;

  msx_slot_bridge #(.TIMEOUT(16)) dut (
    .clk(clk), .n_reset(n_reset), .slot_a(slot_a), .slot_d_in(slot_d_in),
    .slot_d_out(slot_d_out), .slot_d_oe(slot_d_oe),
    .slot_n_rd(slot_n_rd), .slot_n_wr(slot_n_wr), .slot_n_iorq(slot_n_iorq),
    .slot_n_merq(slot_n_merq), .slot_n_m1(slot_n_m1), .slot_n_sltsl(slot_n_sltsl),
    .slot_n_wait(slot_n_wait), .bus_address(bus_address), .bus_write_data(bus_write_data),
    .bus_read(bus_read), .bus_write(bus_write), .bus_io(bus_io), .bus_memory(bus_memory),
    .bus_io_cs(bus_io_cs), .bus_memory_cs(bus_memory_cs),
    .bus_read_ready(bus_read_ready), .bus_read_data(bus_read_data)
  );

  initial forever #5 clk = ~clk;

  // Responder: one-cycle ready resp_delay clocks after seeing a bus_read pulse.
  initial forever begin
    @(posedge clk);
    #1;
    if (resp_cnt > 0) begin
      resp_cnt = resp_cnt - 1;
      if (resp_cnt == 0) begin
        bus_read_ready = 1'b1;
        bus_read_data  = resp_data;
      end
    end else begin
      bus_read_ready = 1'b0;
      if (bus_read && resp_en) resp_cnt = resp_delay;
    end
  end

  function automatic logic [31:0] txn(logic rd, logic wr, logic io, logic mem,
                                      logic [15:0] a, logic [7:0] d);
    return {4'b0000, rd, wr, io, mem, a, d};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs at negedge, feed the scoreboard, return at posedge+2.
  task automatic tick();
    logic [31:0] e;
    logic [7:0]  d;
    @(negedge clk);
    if (n_reset && (bus_read || bus_write)) begin
      pulses++;
      chk("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("bus_txn", txn(bus_read, bus_write, bus_io, bus_memory, bus_address,
                           bus_write ? bus_write_data : 8'h00), e);
      end
    end
    if (!slot_n_wait) wait_low++;
    if (slot_d_oe) oe_hi++;
    if (slot_d_oe && !oe_prev) begin
      chk("drive_expected", 32'(rd_q.size() != 0), 32'd1);
      if (rd_q.size() != 0) begin
        d = rd_q.pop_front();
        chk("read_data", 32'(slot_d_out), 32'(d));
      end
    end
    oe_prev = slot_d_oe;
    @(posedge clk);
    #2;
  endtask

  task automatic release_all();
    slot_n_rd = 1'b1; slot_n_wr = 1'b1; slot_n_iorq = 1'b1;
    slot_n_merq = 1'b1; slot_n_m1 = 1'b1; slot_n_sltsl = 1'b1;
  endtask

  task automatic snap();
    p0 = pulses; w0 = wait_low; o0 = oe_hi;
  endtask

  initial begin
    // Reset values
    repeat (3) tick();
    chk("rst_wait", 32'(slot_n_wait), 32'd1);
    chk("rst_oe", 32'(slot_d_oe), 32'd0);
    chk("rst_dout", 32'(slot_d_out), 32'h00);
    chk("rst_addr", 32'(bus_address), 32'h0000);
    chk("rst_wdata", 32'(bus_write_data), 32'h00);
    chk("rst_pulses", 32'({bus_read, bus_write, bus_io, bus_memory}), 32'd0);
    n_reset = 1'b1;
    tick();

    // I/O write
    snap();
    exp_q.push_back(txn(1'b0, 1'b1, 1'b1, 1'b0, 16'h4301, 8'h93));
    slot_a = 16'h4301; slot_d_in = 8'h93; bus_io_cs = 1'b1;
    slot_n_iorq = 1'b0; slot_n_wr = 1'b0;
    repeat (8) tick();
    release_all();
    repeat (6) tick();
    chk("iow_pulses", 32'(pulses - p0), 32'd1);
    chk("iow_addr", 32'(bus_address), 32'h4301);
    chk("iow_wdata", 32'(bus_write_data), 32'h93);
    chk("iow_no_wait", 32'(wait_low - w0), 32'd0);

    // I/O read, responder answers 2 clk after the pulse
    snap();
    resp_en = 1'b1; resp_delay = 2; resp_data = 8'hA5;
    exp_q.push_back(txn(1'b1, 1'b0, 1'b1, 1'b0, 16'h00A8, 8'h00));
    rd_q.push_back(8'hA5);
    slot_a = 16'h00A8; slot_n_iorq = 1'b0; slot_n_rd = 1'b0;
    for (int i = 0; i < 20 && !slot_d_oe; i++) tick();
    chk("ior_oe_rise", 32'(slot_d_oe), 32'd1);
    chk("ior_wait_cycles", 32'(wait_low - w0), 32'd3);
    chk("ior_wait_off", 32'(slot_n_wait), 32'd1);
    repeat (5) tick();
    chk("ior_oe_hold", 32'(slot_d_oe), 32'd1);
    chk("ior_dout", 32'(slot_d_out), 32'hA5);
    release_all();
    n = 0;
    for (int i = 0; i < 10 && slot_d_oe; i++) begin
      tick();
      n++;
    end
    chk("ior_oe_fall", 32'(slot_d_oe), 32'd0);
    chk("ior_oe_fall_lat", 32'(n <= 3), 32'd1);
    repeat (3) tick();
    chk("ior_pulses", 32'(pulses - p0), 32'd1);
    resp_en = 1'b0;

    // Memory read, sltsl active but device does not claim memory
    snap();
    slot_a = 16'h0001; bus_io_cs = 1'b1; bus_memory_cs = 1'b0;
    slot_n_sltsl = 1'b0; slot_n_merq = 1'b0; slot_n_rd = 1'b0;
    repeat (10) tick();
    release_all();
    repeat (4) tick();
    // Same read with the slot not selected
    bus_memory_cs = 1'b1;
    slot_n_merq = 1'b0; slot_n_rd = 1'b0;
    repeat (10) tick();
    release_all();
    repeat (4) tick();
    chk("mem_nc_pulses", 32'(pulses - p0), 32'd0);
    chk("mem_nc_wait", 32'(wait_low - w0), 32'd0);
    chk("mem_nc_oe", 32'(oe_hi - o0), 32'd0);

    // Memory write with slot selected and claimed
    snap();
    exp_q.push_back(txn(1'b0, 1'b1, 1'b0, 1'b1, 16'h8000, 8'h3C));
    slot_a = 16'h8000; slot_d_in = 8'h3C;
    slot_n_sltsl = 1'b0; slot_n_merq = 1'b0; slot_n_wr = 1'b0;
    repeat (8) tick();
    release_all();
    repeat (5) tick();
    chk("memw_pulses", 32'(pulses - p0), 32'd1);
    chk("memw_wdata", 32'(bus_write_data), 32'h3C);

    // I/O read timeout: no responder
    snap();
    bus_memory_cs = 1'b0;
    exp_q.push_back(txn(1'b1, 1'b0, 1'b1, 1'b0, 16'h00B0, 8'h00));
    slot_a = 16'h00B0; slot_n_iorq = 1'b0; slot_n_rd = 1'b0;
    repeat (40) tick();
    chk("to_wait_cycles", 32'(wait_low - w0), 32'd17);
    chk("to_pulses", 32'(pulses - p0), 32'd1);
    chk("to_oe", 32'(oe_hi - o0), 32'd0);
    release_all();
    repeat (5) tick();

    // Interrupt acknowledge, then a 1-clk glitch on wr during iorq
    snap();
    slot_n_iorq = 1'b0; slot_n_m1 = 1'b0;
    repeat (8) tick();
    release_all();
    repeat (4) tick();
    slot_n_iorq = 1'b0;
    repeat (2) tick();
    slot_n_wr = 1'b0;
    tick();
    slot_n_wr = 1'b1;
    repeat (8) tick();
    release_all();
    repeat (4) tick();
    chk("inta_glitch_pulses", 32'(pulses - p0), 32'd0);
    chk("inta_glitch_wait", 32'(wait_low - w0), 32'd0);

    // Reset while WAIT is held low
    exp_q.push_back(txn(1'b1, 1'b0, 1'b1, 1'b0, 16'h00C0, 8'h00));
    slot_a = 16'h00C0; slot_n_iorq = 1'b0; slot_n_rd = 1'b0;
    for (int i = 0; i < 20 && slot_n_wait; i++) tick();
    chk("mr_wait_low", 32'(slot_n_wait), 32'd0);
    repeat (3) tick();
    #1 n_reset = 1'b0;
    #1;
    chk("mr_wait_rel", 32'(slot_n_wait), 32'd1);
    chk("mr_oe", 32'(slot_d_oe), 32'd0);
    chk("mr_read", 32'(bus_read), 32'd0);
    release_all();
    repeat (2) tick();
    n_reset = 1'b1;
    tick();

    // I/O write after reset
    snap();
    exp_q.push_back(txn(1'b0, 1'b1, 1'b1, 1'b0, 16'h1234, 8'h5A));
    slot_a = 16'h1234; slot_d_in = 8'h5A;
    slot_n_iorq = 1'b0; slot_n_wr = 1'b0;
    repeat (8) tick();
    release_all();
    repeat (6) tick();
    chk("post_rst_pulses", 32'(pulses - p0), 32'd1);
    chk("post_rst_addr", 32'(bus_address), 32'h1234);
    chk("post_rst_wdata", 32'(bus_write_data), 32'h5A);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("rd_q_drained", 32'(rd_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
